// File: rtl/neo_frame_engine.sv
// neo_frame_engine
//
// Frame-based generalised k-lag NEO: psi[c] = x[c]^2 - x[c-K]*x[c+K].
// On an accepted start the engine streams len samples out of an async-read
// sample memory, slides them through a 2*KMAX deep window and writes one
// scaled, saturated result per sample into the result memory. It also
// reports the frame peak and the number of clipped results.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             start request, honoured only in IDLE
//   len_i, lag_i,       frame length, lag K, output right-shift;
//   shift_i             latched when start is accepted
//   busy_o              frame in progress
//   done_o, err_o       end-of-frame pulse; err_o marks a rejected config
//   raddr_o / rdata_i   sample memory read port (combinational data)
//   we_o, waddr_o,      registered result write port
//   wdata_o
//   peak_o              max result written this frame
//   sat_count_o         number of clipped results this frame (sticky max)
//
// state  | meaning
// S_IDLE | waiting for start; validates config
// S_RUN  | streaming samples in, results out
// S_FIN  | one-cycle done pulse, back to IDLE

module neo_frame_engine #(
    parameter int N    = 16,
    parameter int M    = 32,
    parameter int KMAX = 4,
    parameter int AW   = $clog2(M),
    parameter int LW   = $clog2(KMAX) + 1,
    parameter int SW   = $clog2(2 * N)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [AW:0]         len_i,
    input  logic [LW-1:0]       lag_i,
    input  logic [SW-1:0]       shift_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [AW-1:0]       raddr_o,
    input  logic signed [N-1:0] rdata_i,
    output logic                we_o,
    output logic [AW-1:0]       waddr_o,
    output logic signed [N-1:0] wdata_o,
    output logic signed [N-1:0] peak_o,
    output logic [AW:0]         sat_count_o
);

    localparam int CW = AW + 3;
    localparam int IW = $clog2(2 * KMAX);

    localparam logic signed [2*N:0] SAT_HI = $signed({{(N+2){1'b0}}, {(N-1){1'b1}}});
    localparam logic signed [2*N:0] SAT_LO = $signed({{(N+2){1'b1}}, {(N-1){1'b0}}});

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       t_q, t_d;
    logic [AW:0]         len_q, len_d;
    logic [LW-1:0]       lag_q, lag_d;
    logic [SW-1:0]       shift_q, shift_d;
    logic                we_q, we_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic signed [N-1:0] wdata_q, wdata_d;
    logic signed [N-1:0] peak_q, peak_d;
    logic [AW:0]         sat_q, sat_d;
    logic                rej_q, rej_d;

    // win_q[j] holds x[t-1-j] during RUN cycle t
    logic signed [N-1:0] win_q [2*KMAX];

    logic                cfg_ok;
    logic                accept;
    logic                shift_en;
    logic [CW-1:0]       len_c, lag_c, lag2_c, t_end;
    logic [IW-1:0]       idx_c, idx_m;
    logic signed [N-1:0] x_c, x_m, x_p;
    logic signed [2*N-1:0] sq, cr;
    logic signed [2*N:0] diff, shifted;
    logic signed [N-1:0] res;
    logic                clip;

    assign cfg_ok = (int'(lag_i) >= 1) && (int'(lag_i) <= KMAX) &&
                    (int'(len_i) >= 1) && (int'(len_i) <= M) &&
                    (int'(len_i) >= 2 * int'(lag_i) + 1);
    assign accept = (state_q == S_IDLE) && start_i && cfg_ok;

    assign len_c  = CW'(len_q);
    assign lag_c  = CW'(lag_q);
    assign lag2_c = CW'({lag_q, 1'b0});
    assign t_end  = len_c + lag_c;

    assign shift_en = (state_q == S_RUN) && (t_q < len_c);

    // Datapath: in cycle t the result for c = t - lag is formed from
    // x[c] = win[lag-1], x[c-lag] = win[2*lag-1] and x[c+lag] = live rdata.
    always_comb begin
        idx_c   = IW'(lag_q) - IW'(1);
        idx_m   = IW'({lag_q, 1'b0}) - IW'(1);
        x_p     = rdata_i;
        x_c     = win_q[idx_c];
        x_m     = win_q[idx_m];
        sq      = (2*N)'(x_c) * (2*N)'(x_c);
        cr      = (2*N)'(x_m) * (2*N)'(x_p);
        diff    = (2*N+1)'(sq) - (2*N+1)'(cr);
        shifted = diff >>> shift_q;
        res     = '0;
        clip    = 1'b0;
        // Edge samples (c < lag or c >= len-lag) have no full neighbourhood
        if ((t_q >= lag2_c) && (t_q < len_c)) begin
            if (shifted > SAT_HI) begin
                res  = SAT_HI[N-1:0];
                clip = 1'b1;
            end else if (shifted < SAT_LO) begin
                res  = SAT_LO[N-1:0];
                clip = 1'b1;
            end else begin
                res = shifted[N-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = '0;
        len_d   = len_q;
        lag_d   = lag_q;
        shift_d = shift_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        peak_d  = peak_q;
        sat_d   = sat_q;
        rej_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (cfg_ok) begin
                        state_d = S_RUN;
                        len_d   = len_i;
                        lag_d   = lag_i;
                        shift_d = shift_i;
                        peak_d  = '0;
                        sat_d   = '0;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                t_d = t_q + CW'(1);
                if ((t_q >= lag_c) && (t_q < t_end)) begin
                    we_d    = 1'b1;
                    waddr_d = AW'(t_q - lag_c);
                    wdata_d = res;
                    if (res > peak_q) begin
                        peak_d = res;
                    end
                    if (clip && (sat_q != '1)) begin
                        sat_d = sat_q + (AW+1)'(1);
                    end
                end
                if (t_q == t_end) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            len_q   <= '0;
            lag_q   <= '0;
            shift_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            peak_q  <= '0;
            sat_q   <= '0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            len_q   <= len_d;
            lag_q   <= lag_d;
            shift_q <= shift_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            peak_q  <= peak_d;
            sat_q   <= sat_d;
            rej_q   <= rej_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2 * KMAX; i++) begin
                win_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < 2 * KMAX; i++) begin
                win_q[i] <= '0;
            end
        end else if (shift_en) begin
            win_q[0] <= rdata_i;
            for (int i = 1; i < 2 * KMAX; i++) begin
                win_q[i] <= win_q[i-1];
            end
        end
    end

    always_comb begin
        raddr_o = '0;
        if (state_q == S_RUN) begin
            raddr_o = (t_q < len_c) ? AW'(t_q) : AW'(len_q - (AW+1)'(1));
        end
    end

    assign busy_o      = (state_q == S_RUN);
    assign done_o      = (state_q == S_FIN) || rej_q;
    assign err_o       = rej_q;
    assign we_o        = we_q;
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;
    assign peak_o      = peak_q;
    assign sat_count_o = sat_q;

endmodule

// File: tb/tb_neo_frame_engine.sv
module tb_neo_frame_engine;

    localparam int N  = 16;
    localparam int M  = 32;
    localparam int AW = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [AW:0]        len_i = '0;
    logic [2:0]         lag_i = '0;
    logic [4:0]         shift_i = '0;
    logic               busy, done, err, we;
    logic [AW-1:0]      raddr, waddr;
    logic signed [N-1:0] rdata, wdata, peak;
    logic [AW:0]        sat_count;

    logic signed [N-1:0] mem [M];
    int exp_w [M];
    int exp_peak, exp_sat;
    int n_checks = 0;
    int n_err = 0;

    assign rdata = mem[raddr];

    always #5 clk = ~clk;

    neo_frame_engine #(.N(N), .M(M), .KMAX(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .len_i       (len_i),
        .lag_i       (lag_i),
        .shift_i     (shift_i),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .raddr_o     (raddr),
        .rdata_i     (rdata),
        .we_o        (we),
        .waddr_o     (waddr),
        .wdata_o     (wdata),
        .peak_o      (peak),
        .sat_count_o (sat_count)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < M; i++) mem[i] = 16'(i);
    endtask

    // One full frame; cycle t = 0 is the first RUN cycle
    task automatic run_frame(input int len, input int lag, input int sh, input string nm);
        @(posedge clk); #1;
        start = 1'b1; len_i = 6'(len); lag_i = 3'(lag); shift_i = 5'(sh);
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t <= len + lag + 1; t++) begin
            @(negedge clk);
            if (t == 0) chk({nm, " busy_t0"}, 64'(busy), 64'(1));
            chk({nm, " we"}, 64'(we), 64'((t >= lag + 1 && t <= len + lag) ? 1 : 0));
            if (t >= lag + 1 && t <= len + lag) begin
                chk({nm, " waddr"}, 64'(waddr), 64'(t - lag - 1));
                chk({nm, " wdata"}, 64'(wdata), 64'(exp_w[t - lag - 1]));
            end
            if (t == len + lag + 1) begin
                chk({nm, " done"}, 64'(done), 64'(1));
                chk({nm, " err"}, 64'(err), 64'(0));
                chk({nm, " busy_end"}, 64'(busy), 64'(0));
                chk({nm, " peak"}, 64'(peak), 64'(exp_peak));
                chk({nm, " sat"}, 64'(sat_count), 64'(exp_sat));
            end else begin
                chk({nm, " done_early"}, 64'(done), 64'(0));
            end
        end
    endtask

    task automatic bad_cfg(input int len, input int lag, input string nm);
        @(posedge clk); #1;
        start = 1'b1; len_i = 6'(len); lag_i = 3'(lag); shift_i = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({nm, " done"}, 64'(done), 64'(1));
        chk({nm, " err"}, 64'(err), 64'(1));
        chk({nm, " we"}, 64'(we), 64'(0));
        chk({nm, " busy"}, 64'(busy), 64'(0));
        @(negedge clk);
        chk({nm, " done_clr"}, 64'(done), 64'(0));
        chk({nm, " we2"}, 64'(we), 64'(0));
    endtask

    initial begin
        fill_ramp();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst err", 64'(err), 64'(0));
        chk("rst we", 64'(we), 64'(0));
        chk("rst raddr", 64'(raddr), 64'(0));
        chk("rst waddr", 64'(waddr), 64'(0));
        chk("rst wdata", 64'(wdata), 64'(0));
        chk("rst peak", 64'(peak), 64'(0));
        chk("rst sat", 64'(sat_count), 64'(0));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle we", 64'(we), 64'(0));
            chk("idle busy", 64'(busy), 64'(0));
        end

        // lag 1, len 8, ramp
        exp_w = '{default: 0};
        for (int c = 1; c <= 6; c++) exp_w[c] = 1;
        exp_peak = 1; exp_sat = 0;
        run_frame(8, 1, 0, "lag1");

        // lag 2, len 10, ramp
        exp_w = '{default: 0};
        for (int c = 2; c <= 7; c++) exp_w[c] = 4;
        exp_peak = 4; exp_sat = 0;
        run_frame(10, 2, 0, "lag2");

        // Alternating large samples: saturation, then shifted
        for (int i = 0; i < 6; i++) mem[i] = (i % 2 == 1) ? 16'sd30000 : 16'sd0;
        exp_w = '{default: 0};
        exp_w[1] = 32767; exp_w[2] = -32768; exp_w[3] = 32767; exp_w[4] = -32768;
        exp_peak = 32767; exp_sat = 4;
        run_frame(6, 1, 0, "sat");

        exp_w = '{default: 0};
        exp_w[1] = 27465; exp_w[2] = -27466; exp_w[3] = 27465; exp_w[4] = -27466;
        exp_peak = 27465; exp_sat = 0;
        run_frame(6, 1, 15, "shift15");

        // Rejected configurations
        bad_cfg(6, 3, "len_short");
        bad_cfg(8, 0, "lag0");
        bad_cfg(20, 5, "lag_big");
        bad_cfg(0, 1, "len0");

        // Long frame, ignored restart, then reset mid-frame
        fill_ramp();
        exp_w = '{default: 0};
        for (int c = 1; c <= 30; c++) exp_w[c] = 1;
        @(posedge clk); #1;
        start = 1'b1; len_i = 6'd32; lag_i = 3'd1; shift_i = '0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t == 4) begin start = 1'b1; len_i = 6'd6; lag_i = 3'd3; end
            if (t == 5) start = 1'b0;
            chk("mid busy", 64'(busy), 64'(1));
            chk("mid we", 64'(we), 64'((t >= 2) ? 1 : 0));
            if (t >= 2) begin
                chk("mid waddr", 64'(waddr), 64'(t - 2));
                chk("mid wdata", 64'(wdata), 64'(exp_w[t - 2]));
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst busy", 64'(busy), 64'(0));
        chk("midrst we", 64'(we), 64'(0));
        chk("midrst done", 64'(done), 64'(0));
        chk("midrst waddr", 64'(waddr), 64'(0));
        chk("midrst wdata", 64'(wdata), 64'(0));
        chk("midrst peak", 64'(peak), 64'(0));
        chk("midrst raddr", 64'(raddr), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Full-length frame at maximum lag after reset
        exp_w = '{default: 0};
        for (int c = 4; c <= 27; c++) exp_w[c] = 16;
        exp_peak = 16; exp_sat = 0;
        run_frame(32, 4, 0, "full32");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/neo_frame_engine.md
Name: neo_frame_engine

Overview:
Parametrised successor to the single-lag NEO calculator. It processes one frame of stored samples per start command and computes the generalised k-lag NEO psi[c] = x[c]^2 - x[c-K]*x[c+K], with runtime-selectable lag K, frame length, output scaling and saturation. It reads from an asynchronous-read sample memory and writes results to an output memory. It sits between the sample buffer and the spike-detection stage, and reports a per-frame peak and a saturation count.

Parameters:
N, 16, sample and result width (signed)
M, 32, memory depth; AW = $clog2(M)
KMAX, 4, maximum supported lag; window holds 2*KMAX samples; LW = $clog2(KMAX)+1

Ports:
Clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; honoured only in IDLE
len  in  AW+1  frame length in samples, 1..M; sampled at accepted start
lag  in  LW  lag K, 1..KMAX; sampled at accepted start
shift  in  $clog2(2N)  arithmetic right shift applied before saturation; sampled at start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at end of frame (normal or error)
err  out  1  valid with done; config rejected
raddr  out  AW  sample memory read address; rdata is combinational from raddr
rdata  in  N  signed sample
we  out  1  result write enable (registered)
waddr  out  AW  result write address (registered)
wdata  out  N  signed result (registered)
peak  out  N  max wdata written this frame (signed)
sat_count  out  AW+1  number of clipped results this frame

Behaviour:
- Reset (any time, including mid-frame): state IDLE; busy, done, err, we = 0; raddr, waddr, wdata, peak, sat_count = 0; window cleared. Writes stop immediately.
- States: IDLE, RUN, FIN.
- IDLE + start: validate config (lag != 0, lag <= KMAX, 1 <= len <= M, len >= 2*lag+1).
  - Invalid: stay IDLE; next cycle done=1, err=1; no we.
  - Valid: latch config; clear peak and sat_count to 0; enter RUN.
- start while busy is ignored; config changes while busy have no effect.
- RUN cycle t (t=0 is the first RUN cycle):
  - For t < len: raddr = t, and rdata is shifted into the window at the clock edge. raddr holds len-1 afterwards.
  - Result for index c is written at cycle c+lag+1 (registered), for c = 0..len-1. we is therefore high for exactly len consecutive cycles: lag+1..len+lag.
- Value: for c < lag or c >= len-lag, wdata = 0. Otherwise, computed at cycle c+lag from window x[c], x[c-lag] and live rdata = x[c+lag]:
  - Products are 2N-bit; the difference is 2N+1-bit signed.
  - Then apply an arithmetic shift right by shift (floor).
  - Then saturate to [-2^(N-1), 2^(N-1)-1]. A clip increments sat_count, which sticks at its max.
- peak = max of all wdata written this frame, updated with we.
- After the last write (cycle len+lag), go to FIN. At cycle len+lag+1: done=1, err=0, busy=0. Then IDLE.
- done and start in the same cycle: done completes; start is accepted only if the state is IDLE.

Test Plan:
- Reset asserted, then released -> all outputs 0, IDLE; no we for 20 cycles without start.
- N=16, lag=1, shift=0, len=8, x[i]=i -> waddr 0..7 at cycles 2..9, wdata 0,1,1,1,1,1,1,0; peak=1, sat_count=0; done at cycle 10.
- lag=2, len=10, x[i]=i -> wdata 0,0,4,4,4,4,4,4,0,0 at cycles 3..12; done at cycle 13.
- lag=1, len=6, x=0,30000,0,30000,0,30000, with shift=0 and then shift=15:
  - shift=0 -> 0,32767,-32768,32767,-32768,0; sat_count=4; peak=32767.
  - shift=15 -> 0,27465,-27466,27465,-27466,0; sat_count=0.
- lag=3, len=6 -> done=1, err=1 one cycle after start; we never asserted.
- Start a len=32 frame, pulse start again at cycle 5 -> ignored. Assert reset at cycle 10 -> busy, we drop immediately; a new start after release runs a full, correct frame.
